// File: rtl/step_pulse_seq_if.sv
// step_pulse_seq_if: command/status bundle between the motion register block and the step sequencer
interface step_pulse_seq_if #(
  parameter int PERIOD_W = 16,
  parameter int STEPS_W  = 32
);
  logic                start;
  logic [PERIOD_W-1:0] period;
  logic [STEPS_W-1:0]  steps;
  logic                dir_in;
  logic                period_wr;
  logic                abort;
  logic                step_out;
  logic                dir_out;
  logic                busy;
  logic                done;
  logic                aborted;
  logic [STEPS_W-1:0]  steps_done;
  logic                err;
  modport master (
    output start, period, steps, dir_in, period_wr, abort,
    input  step_out, dir_out, busy, done, aborted, steps_done, err
  );
  modport slave (
    input  start, period, steps, dir_in, period_wr, abort,
    output step_out, dir_out, busy, done, aborted, steps_done, err
  );
endinterface

// File: rtl/step_pulse_seq.sv
// step_pulse_seq: step/direction sequencer with setup delay, live period updates and pulse-safe abort
module step_pulse_seq #(
  parameter int PERIOD_W   = 16,
  parameter int STEPS_W    = 32,
  parameter int SETUP_CYC  = 2,
  parameter int MIN_PERIOD = 4
) (
  input logic clk,
  input logic rst,
  step_pulse_seq_if.slave bus
);
  localparam int SC_W = $clog2(SETUP_CYC + 1);
  typedef enum logic [1:0] {IDLE, SETUP, RUN} state_t;
  state_t              state;
  logic [PERIOD_W-1:0] per_q, pend_q, k, per_nx, k_nx;
  logic [STEPS_W-1:0]  steps_q;
  logic [SC_W-1:0]     sc;
  logic                pend_v, abort_q, per_ok, wr_ok, k_last, high, last_step, abort_any;
  assign per_ok    = bus.period >= PERIOD_W'(MIN_PERIOD);
  assign wr_ok     = bus.period_wr && per_ok;
  // a legal write landing on the last phase cycle still reaches the very next step
  assign per_nx    = wr_ok ? bus.period : pend_v ? pend_q : per_q;
  assign k_nx      = k + 1'b1;
  assign k_last    = k == per_q - 1'b1;
  assign high      = k >= (per_q >> 1);
  assign last_step = bus.steps_done == steps_q - 1'b1;
  assign abort_any = bus.abort || abort_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      per_q          <= '0;
      pend_q         <= '0;
      pend_v         <= 1'b0;
      abort_q        <= 1'b0;
      k              <= '0;
      sc             <= '0;
      steps_q        <= '0;
      bus.step_out   <= 1'b0;
      bus.dir_out    <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.aborted    <= 1'b0;
      bus.steps_done <= '0;
      bus.err        <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      if (bus.busy && bus.period_wr) begin
        if (per_ok) begin
          pend_q <= bus.period;
          pend_v <= 1'b1;
        end else bus.err <= 1'b1;
      end
      case (state)
        IDLE: if (bus.start) begin
          if (per_ok && bus.steps != '0) begin
            state          <= SETUP;
            per_q          <= bus.period;
            steps_q        <= bus.steps;
            bus.dir_out    <= bus.dir_in;
            bus.busy       <= 1'b1;
            bus.steps_done <= '0;
            bus.aborted    <= 1'b0;
            pend_v         <= 1'b0;
            abort_q        <= 1'b0;
            sc             <= '0;
          end else bus.err <= 1'b1;
        end
        SETUP: if (bus.abort) begin
          state       <= IDLE;
          bus.busy    <= 1'b0;
          bus.done    <= 1'b1;
          bus.aborted <= 1'b1;
        end else if (sc == SC_W'(SETUP_CYC - 1)) begin
          state        <= RUN;
          k            <= '0;
          per_q        <= per_nx;
          pend_v       <= 1'b0;
          bus.step_out <= 1'b0;
        end else sc <= sc + 1'b1;
        RUN: if (abort_any && !high) begin
          state       <= IDLE;
          bus.busy    <= 1'b0;
          bus.done    <= 1'b1;
          bus.aborted <= 1'b1;
        end else if (k_last) begin
          bus.steps_done <= bus.steps_done + 1'b1;
          bus.step_out   <= 1'b0;
          if (last_step || abort_any) begin
            state       <= IDLE;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b1;
            bus.aborted <= !last_step;
          end else begin
            k      <= '0;
            per_q  <= per_nx;
            pend_v <= 1'b0;
          end
        end else begin
          k            <= k_nx;
          bus.step_out <= k_nx >= (per_q >> 1);
          if (bus.abort) abort_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_step_pulse_seq.sv
// tb_step_pulse_seq: directed and random stimulus against a step-schedule reference model
module tb_step_pulse_seq;
  localparam int PW = 16, SW = 32, SC = 2, MP = 4;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  step_pulse_seq_if #(.PERIOD_W(PW), .STEPS_W(SW)) bus();
  step_pulse_seq #(.PERIOD_W(PW), .STEPS_W(SW), .SETUP_CYC(SC), .MIN_PERIOD(MP)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  int errors = 0, checks = 0;
  int cyc = 0, t0 = 0, done_rel = -1, done_ab = 0, err_seen = 0;
  // model: move progress as setup cycles left, elapsed cycles in current step, and its period
  int m_busy, m_dir, m_sd, m_req, m_p, m_pend, m_setup, m_t, m_abl, m_ab, e_done, e_err;
  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic m_reset();
    m_busy = 0; m_dir = 0; m_sd = 0; m_req = 0; m_p = 0; m_pend = -1;
    m_setup = 0; m_t = 0; m_abl = 0; m_ab = 0; e_done = 0; e_err = 0;
  endtask
  task automatic m_finish(input int ab);
    m_busy = 0; e_done = 1; m_ab = ab;
  endtask
  task automatic model_step(input int s, input int per, input int stp, input int d, input int wr, input int ab);
    e_done = 0; e_err = 0;
    if (!m_busy) begin
      if (s) begin
        if (per >= MP && stp != 0) begin
          m_busy = 1; m_dir = d; m_sd = 0; m_ab = 0; m_req = stp; m_p = per;
          m_pend = -1; m_setup = SC; m_t = 0; m_abl = 0;
        end else e_err = 1;
      end
    end else begin
      if (wr) begin
        if (per >= MP) m_pend = per; else e_err = 1;
      end
      if (m_setup > 0) begin
        if (ab) m_finish(1);
        else begin
          m_setup--;
          if (m_setup == 0) begin
            m_t = 0;
            if (m_pend >= 0) begin m_p = m_pend; m_pend = -1; end
          end
        end
      end else if (ab && m_t < m_p / 2) m_finish(1);
      else begin
        if (ab) m_abl = 1;
        m_t++;
        if (m_t == m_p) begin
          m_sd++;
          if (m_sd == m_req) m_finish(0);
          else if (m_abl) m_finish(1);
          else begin
            m_t = 0;
            if (m_pend >= 0) begin m_p = m_pend; m_pend = -1; end
          end
        end
      end
    end
  endtask
  task automatic tick(input int s, input int per, input int stp, input int d, input int wr, input int ab);
    bus.start = 1'(s); bus.period = PW'(per); bus.steps = SW'(stp);
    bus.dir_in = 1'(d); bus.period_wr = 1'(wr); bus.abort = 1'(ab);
    @(negedge clk);
    chk("step_out", bus.step_out, (m_busy && m_setup == 0 && m_t >= m_p / 2) ? 1 : 0);
    chk("dir_out", bus.dir_out, m_dir);
    chk("busy", bus.busy, m_busy);
    chk("done", bus.done, e_done);
    chk("err", bus.err, e_err);
    chk("steps_done", bus.steps_done, m_sd);
    if (e_done) chk("aborted", bus.aborted, m_ab);
    if (bus.done && done_rel < 0) begin done_rel = cyc - t0; done_ab = bus.aborted; end
    if (bus.err) err_seen = 1;
    if (!rst) m_reset(); else model_step(s, per, stp, d, wr, ab);
    cyc++;
    @(posedge clk);
    #1;
  endtask
  task automatic run_move(input int p, input int s, input int d, input int ab_at, input int wr_at,
                          input int wr_v, input int exp_rel, input int exp_sd, input int exp_ab);
    t0 = cyc; done_rel = -1;
    tick(1, p, s, d, 0, 0);
    for (int r = 1; r < 600 && done_rel < 0; r++)
      tick(0, r == wr_at ? wr_v : p, s, d, r == wr_at ? 1 : 0, r == ab_at ? 1 : 0);
    chk("done_at", done_rel, exp_rel);
    chk("final_steps", bus.steps_done, exp_sd);
    chk("final_aborted", done_ab, exp_ab);
    tick(0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    bus.start = 0; bus.period = '0; bus.steps = '0; bus.dir_in = 0; bus.period_wr = 0; bus.abort = 0;
    m_reset();
    @(posedge clk);
    #1;
    tick(0, 0, 0, 0, 0, 0);
    tick(1, 10, 3, 1, 0, 0);
    rst = 1'b1;
    tick(0, 0, 0, 0, 0, 0);
    run_move(10, 3, 1, -1, -1, 0, 33, 3, 0);
    run_move(7, 2, 0, -1, -1, 0, 17, 2, 0);
    run_move(10, 5, 1, 15, -1, 0, 16, 1, 1);
    run_move(10, 5, 1, 19, -1, 0, 23, 2, 1);
    run_move(10, 4, 0, -1, 9, 6, 31, 4, 0);
    run_move(10, 2, 1, -1, 5, 3, 23, 2, 0);
    run_move(8, 3, 0, 1, -1, 0, 2, 0, 1);
    run_move(5, 1, 1, 8, -1, 0, 8, 1, 0);
    err_seen = 0;
    tick(1, 3, 5, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    chk("err_period3", err_seen, 1);
    chk("busy_period3", bus.busy, 0);
    err_seen = 0;
    tick(1, 10, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    chk("err_steps0", err_seen, 1);
    chk("busy_steps0", bus.busy, 0);
    t0 = cyc;
    tick(1, 10, 3, 1, 0, 0);
    for (int r = 1; r <= 9; r++) tick(0, 10, 3, 1, 0, 0);
    chk("pre_rst_step", bus.step_out, 1);
    #2 rst = 1'b0;
    #1;
    chk("rst_step", bus.step_out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_dir", bus.dir_out, 0);
    chk("rst_steps", bus.steps_done, 0);
    chk("rst_done", bus.done, 0);
    m_reset();
    @(posedge clk);
    #1;
    tick(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick(0, 0, 0, 0, 0, 0);
    run_move(8, 2, 1, -1, -1, 0, 19, 2, 0);
    for (int i = 0; i < 3000; i++)
      tick($urandom_range(0, 7) == 0, $urandom_range(2, 12), $urandom_range(0, 4), $urandom_range(0, 1),
           $urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
